operand_bypass_stage: RTL and testbench
=======================================

# operand_bypass_stage

Registered ID→EX operand stage for the pipelined core, the parametrised successor of the combinational ALU A/B operand selectors. It resolves rs1/rs2 through a priority bypass network (MEM, then WB, then register file), applies the A/B source selection, detects load-use hazards and inserts bubbles. It also honours pipeline stall/flush and keeps a saturating hazard counter. It sits between decode/regfile read and the ALU.

## Interface
- XLEN, 64, datapath width
- REG_AW, 5, register index width (x0 = index 0)
- CNT_W, 32, hazard counter width
- clk  in  1  core clock; all state updates on rising edge
- rstn  in  1  reset; asynchronous, active-low
- stall  in  1  downstream hold; EX register keeps its contents
- flush  in  1  kill; EX entry becomes a bubble
- id_valid  in  1  ID holds a real instruction
- id_pc, id_imm, id_rs1_data, id_rs2_data  in  XLEN  decode/regfile values
- id_rs1, id_rs2  in  REG_AW  source indices
- id_asel  in  alu_asel_op_enum; id_bsel  in  alu_bsel_op_enum
- id_store  in  1  instruction uses rs2 as store data
- mem_we, wb_we  in  1  bypass source writes a register
- mem_rd, wb_rd  in  REG_AW; mem_data, wb_data  in  XLEN  bypass sources
- ex_is_load  in  1; ex_rd  in  REG_AW  load currently in EX
- ex_valid  out  1  EX entry valid
- ex_a, ex_b, ex_sdata  out  XLEN  registered ALU operands and store data
- hazard_stall  out  1  combinational request to hold PC/IF/ID
- hazard_cnt  out  CNT_W  saturating count of inserted bubbles

## Operation
- Bypass per source register r with data d:
  - r==0 → 0.
  - Else if mem_we && mem_rd==r → mem_data.
  - Else if wb_we && wb_rd==r → wb_data.
  - Else d.
- A select: ASEL_REG → fwd rs1; ASEL_PC → id_pc; ASEL0/ASEL3/other → 0.
- B select: BSEL_REG → fwd rs2; BSEL_IMM → id_imm; BSEL0/BSEL3/other → 0.
- ex_sdata = fwd rs2, regardless of bsel.
- rs1 is in use iff id_asel==ASEL_REG. rs2 is in use iff id_bsel==BSEL_REG or id_store.
- hazard_stall = id_valid && ex_valid && ex_is_load && ex_rd!=0 && ex_rd matches an in-use source.
  - hazard_stall is held low while stall=1, because EX is not advancing.
- Register update priority at each edge:
  1. flush → ex_valid=0, operands=0.
  2. stall → hold everything.
  3. hazard_stall → bubble: ex_valid=0, operands=0, hazard_cnt+1 (saturates at all-ones).
  4. Otherwise capture: ex_valid=id_valid, ex_a/ex_b/ex_sdata = selected values.
- Invalid IDs (id_valid=0) capture ex_valid=0. Operand values are don't-care but are driven 0.
- flush and hazard in the same cycle → flush wins; counter not incremented.

## Timing
- Latency: 1 cycle from ID inputs to ex_* outputs.
- hazard_stall is combinational, same cycle as the ID inputs. Upstream holds ID for exactly one cycle per load-use.
- Bypass compare uses MEM/WB values present in the capture cycle. A producer leaving MEM into WB during a held ID is picked up from WB on the retry.
- Reset (rstn=0, asynchronous) clears immediately: ex_valid=0, ex_a=ex_b=ex_sdata=0, hazard_cnt=0.
  - hazard_stall follows to 0 because ex_valid=0.
  - Reset mid-stall discards the held entry; first post-reset edge with rstn=1 captures normally.

## Structure
- alu_asel_op_enum, alu_bsel_op_enum and their members live in the shared CPU package. No new types.
- Sub-module fwd_sel (XLEN, REG_AW): combinational priority bypass for one source. Instantiated twice (rs1, rs2).
- Top holds the EX register, hazard detect and counter.

## Test plan
- rs1=5, mem_we=1, mem_rd=5, mem_data=0xAA, wb_we=1, wb_rd=5, wb_data=0xBB, asel=ASEL_REG → next cycle ex_a=0xAA.
- rs2=0, mem_we=1, mem_rd=0, mem_data=0x1234, bsel=BSEL_REG, id_store=1 → ex_b=0, ex_sdata=0.
- ex_is_load=1, ex_rd=7, ex_valid=1, id rs1=7, asel=ASEL_REG → hazard_stall=1, next ex_valid=0, hazard_cnt=1; retry with wb_rd=7, wb_data=0x55 → ex_a=0x55.
- Load-use where rs2=7 but bsel=BSEL_IMM and id_store=0 → hazard_stall=0, ex_b=id_imm.
- stall=1 for 3 cycles with changing ID inputs → ex_* unchanged. Then flush=1 together with stall=1 → ex_valid=0.
- rstn dropped asynchronously mid-stall with ex_valid=1, hazard_cnt=3 → all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/operand_bypass_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : operand_bypass_stage_pkg
//  Description : Shared CPU types for ALU operand source selection.
//  Revision    : 1.0 - initial release
// ============================================================================
package operand_bypass_stage_pkg;

    // ALU operand A source select
    typedef enum logic [1:0] {
        ASEL0    = 2'd0,
        ASEL_REG = 2'd1,
        ASEL_PC  = 2'd2,
        ASEL3    = 2'd3
    } alu_asel_op_enum;

    // ALU operand B source select
    typedef enum logic [1:0] {
        BSEL0    = 2'd0,
        BSEL_REG = 2'd1,
        BSEL_IMM = 2'd2,
        BSEL3    = 2'd3
    } alu_bsel_op_enum;

endpackage
`default_nettype wire

// File: rtl/operand_bypass_stage_fwd_sel.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_sel
//  Description : Priority bypass for one source register (x0, MEM, WB, RF).
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_sel #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [XLEN-1:0]   rf_data,
    input  logic              mem_we,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   fwd_data
);

    // Youngest producer wins; x0 is hardwired to zero even if a stage writes it
    always_comb begin
        fwd_data = rf_data;
        if (rs == '0) begin
            fwd_data = '0;
        end else if (mem_we && (mem_rd == rs)) begin
            fwd_data = mem_data;
        end else if (wb_we && (wb_rd == rs)) begin
            fwd_data = wb_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/operand_bypass_stage.sv
`default_nettype none
// ============================================================================
//  Module      : operand_bypass_stage
//  Description : Registered ID->EX operand stage with bypass, A/B select,
//                load-use hazard bubble insertion and saturating bubble count.
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_bypass_stage
    import operand_bypass_stage_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  alu_asel_op_enum   id_asel,
    input  alu_bsel_op_enum   id_bsel,
    input  logic              id_store,
    input  logic              mem_we,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   mem_data,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_a,
    output logic [XLEN-1:0]   ex_b,
    output logic [XLEN-1:0]   ex_sdata,
    output logic              hazard_stall,
    output logic [CNT_W-1:0]  hazard_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [XLEN-1:0]  w_fwd_rs1;
    logic [XLEN-1:0]  w_fwd_rs2;
    logic [XLEN-1:0]  w_sel_a;
    logic [XLEN-1:0]  w_sel_b;
    logic             w_rs1_use;
    logic             w_rs2_use;
    logic             w_hazard;

    logic             r_ex_valid;
    logic [XLEN-1:0]  r_ex_a;
    logic [XLEN-1:0]  r_ex_b;
    logic [XLEN-1:0]  r_ex_sdata;
    logic [CNT_W-1:0] r_hazard_cnt;

    fwd_sel #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .rs       (id_rs1),
        .rf_data  (id_rs1_data),
        .mem_we   (mem_we),
        .mem_rd   (mem_rd),
        .mem_data (mem_data),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .fwd_data (w_fwd_rs1)
    );

    fwd_sel #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .rs       (id_rs2),
        .rf_data  (id_rs2_data),
        .mem_we   (mem_we),
        .mem_rd   (mem_rd),
        .mem_data (mem_data),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .fwd_data (w_fwd_rs2)
    );

    // Operand source muxes; unused encodings feed zero
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        case (id_asel)
            ASEL_REG: w_sel_a = w_fwd_rs1;
            ASEL_PC:  w_sel_a = id_pc;
            default:  w_sel_a = '0;
        endcase
        case (id_bsel)
            BSEL_REG: w_sel_b = w_fwd_rs2;
            BSEL_IMM: w_sel_b = id_imm;
            default:  w_sel_b = '0;
        endcase
    end

    // Load-use detect; masked while stalled since EX is not advancing anyway
    always_comb begin
        w_rs1_use = (id_asel == ASEL_REG);
        w_rs2_use = (id_bsel == BSEL_REG) || id_store;
        w_hazard  = !stall && id_valid && r_ex_valid && ex_is_load &&
                    (ex_rd != '0) &&
                    ((w_rs1_use && (ex_rd == id_rs1)) ||
                     (w_rs2_use && (ex_rd == id_rs2)));
    end

    // EX register: flush beats stall beats hazard bubble beats capture
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ex_valid   <= 1'b0;
            r_ex_a       <= '0;
            r_ex_b       <= '0;
            r_ex_sdata   <= '0;
            r_hazard_cnt <= '0;
        end else if (flush) begin
            r_ex_valid <= 1'b0;
            r_ex_a     <= '0;
            r_ex_b     <= '0;
            r_ex_sdata <= '0;
        end else if (stall) begin
            r_ex_valid <= r_ex_valid;
        end else if (w_hazard) begin
            r_ex_valid <= 1'b0;
            r_ex_a     <= '0;
            r_ex_b     <= '0;
            r_ex_sdata <= '0;
            if (r_hazard_cnt != c_cnt_max) begin
                r_hazard_cnt <= r_hazard_cnt + 1'b1;
            end
        end else begin
            r_ex_valid <= id_valid;
            r_ex_a     <= id_valid ? w_sel_a   : '0;
            r_ex_b     <= id_valid ? w_sel_b   : '0;
            r_ex_sdata <= id_valid ? w_fwd_rs2 : '0;
        end
    end

    assign ex_valid     = r_ex_valid;
    assign ex_a         = r_ex_a;
    assign ex_b         = r_ex_b;
    assign ex_sdata     = r_ex_sdata;
    assign hazard_stall = w_hazard;
    assign hazard_cnt   = r_hazard_cnt;

endmodule
`default_nettype wire

// File: tb/tb_operand_bypass_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_bypass_stage
//  Description : Scoreboard bench for operand_bypass_stage (directed vectors).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_bypass_stage;
    import operand_bypass_stage_pkg::*;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 2;   // narrow so saturation is reachable

    logic              clk = 1'b0;
    logic              rstn;
    logic              stall, flush, id_valid, id_store;
    logic [XLEN-1:0]   id_pc, id_imm, id_rs1_data, id_rs2_data;
    logic [REG_AW-1:0] id_rs1, id_rs2;
    alu_asel_op_enum   id_asel;
    alu_bsel_op_enum   id_bsel;
    logic              mem_we, wb_we;
    logic [REG_AW-1:0] mem_rd, wb_rd;
    logic [XLEN-1:0]   mem_data, wb_data;
    logic              ex_is_load;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_a, ex_b, ex_sdata;
    logic              hazard_stall;
    logic [CNT_W-1:0]  hazard_cnt;

    operand_bypass_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_asel(id_asel), .id_bsel(id_bsel),
        .id_store(id_store), .mem_we(mem_we), .wb_we(wb_we),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_data(mem_data), .wb_data(wb_data),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_valid(ex_valid),
        .ex_a(ex_a), .ex_b(ex_b), .ex_sdata(ex_sdata),
        .hazard_stall(hazard_stall), .hazard_cnt(hazard_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic        hs;
        logic        v;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] s;
        logic [63:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL c%0d %s: got %h expected %h", idx, nm, act, exp);
        end
    endtask

    task automatic clr();
        stall = 0; flush = 0; id_valid = 0; id_store = 0;
        id_pc = '0; id_imm = '0; id_rs1_data = '0; id_rs2_data = '0;
        id_rs1 = '0; id_rs2 = '0; id_asel = ASEL0; id_bsel = BSEL0;
        mem_we = 0; wb_we = 0; mem_rd = '0; wb_rd = '0;
        mem_data = '0; wb_data = '0; ex_is_load = 0; ex_rd = '0;
    endtask

    task automatic nx();
        @(negedge clk);
        clr();
    endtask

    // expected hazard_stall for this cycle, then EX state after the edge
    task automatic ex(input logic hs, input logic v, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] s, input logic [63:0] cnt);
        exp_t e;
        e.idx = cyc; e.hs = hs; e.v = v; e.a = a; e.b = b; e.s = s; e.cnt = cnt;
        q.push_back(e);
        cyc++;
    endtask

    // Monitor: hazard_stall just before the edge, registered outputs just after
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("hazard_stall", e.idx, {63'd0, hazard_stall}, {63'd0, e.hs});
                @(posedge clk);
                #1;
                chk("ex_valid",   e.idx, {63'd0, ex_valid}, {63'd0, e.v});
                chk("ex_a",       e.idx, ex_a, e.a);
                chk("ex_b",       e.idx, ex_b, e.b);
                chk("ex_sdata",   e.idx, ex_sdata, e.s);
                chk("hazard_cnt", e.idx, {62'd0, hazard_cnt}, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int w;
        clr();
        rstn = 0;
        repeat (2) @(negedge clk);
        chk("rst ex_valid", -1, {63'd0, ex_valid}, 64'd0);
        chk("rst ex_a", -1, ex_a, 64'd0);
        chk("rst ex_b", -1, ex_b, 64'd0);
        chk("rst ex_sdata", -1, ex_sdata, 64'd0);
        chk("rst hazard_cnt", -1, {62'd0, hazard_cnt}, 64'd0);
        chk("rst hazard_stall", -1, {63'd0, hazard_stall}, 64'd0);
        rstn = 1;

        // MEM beats WB for rs1; rs2 misses both
        nx(); id_valid = 1; id_rs1 = 5; mem_we = 1; mem_rd = 5; mem_data = 'hAA;
        wb_we = 1; wb_rd = 5; wb_data = 'hBB; id_asel = ASEL_REG; id_bsel = BSEL_IMM;
        id_imm = 'h10; id_rs2 = 3; id_rs2_data = 'h333;
        ex(0, 1, 'hAA, 'h10, 'h333, 0);
        // x0 is never bypassed
        nx(); id_valid = 1; id_rs2 = 0; mem_we = 1; mem_rd = 0; mem_data = 'h1234;
        id_bsel = BSEL_REG; id_store = 1; id_asel = ASEL_PC; id_pc = 'h1000; id_rs2_data = 'h999;
        ex(0, 1, 'h1000, 0, 0, 0);
        // WB for rs1, MEM for rs2
        nx(); id_valid = 1; id_rs1 = 6; wb_we = 1; wb_rd = 6; wb_data = 'hBB;
        mem_we = 1; mem_rd = 9; mem_data = 'hCC; id_rs2 = 9; id_bsel = BSEL_REG;
        id_rs2_data = 1; id_asel = ASEL_REG;
        ex(0, 1, 'hBB, 'hCC, 'hCC, 0);
        // unused selects give 0; disabled MEM ignored; sdata still forwarded
        nx(); id_valid = 1; id_asel = ASEL3; id_bsel = BSEL0; id_rs1 = 1; id_rs1_data = 'h77;
        id_rs2 = 4; id_rs2_data = 'h44; wb_we = 1; wb_rd = 4; wb_data = 'h4444;
        mem_rd = 4; mem_data = 'hDEAD;
        ex(0, 1, 0, 0, 'h4444, 0);
        // invalid ID captures a zeroed bubble
        nx(); id_asel = ASEL_REG; id_rs1 = 1; id_rs1_data = 5; id_bsel = BSEL_IMM; id_imm = 9;
        ex(0, 0, 0, 0, 0, 0);
        nx(); id_valid = 1; id_asel = ASEL_PC; id_pc = 'h2000; id_bsel = BSEL_IMM; id_imm = 8;
        ex(0, 1, 'h2000, 8, 0, 0);
        // load-use on rs1
        nx(); id_valid = 1; ex_is_load = 1; ex_rd = 7; id_rs1 = 7; id_asel = ASEL_REG; id_rs1_data = 'h11;
        ex(1, 0, 0, 0, 0, 1);
        // retry picks the value from WB
        nx(); id_valid = 1; id_rs1 = 7; id_asel = ASEL_REG; id_rs1_data = 'h11;
        wb_we = 1; wb_rd = 7; wb_data = 'h55;
        ex(0, 1, 'h55, 0, 0, 1);
        // rs2 matches load but is not in use
        nx(); id_valid = 1; ex_is_load = 1; ex_rd = 7; id_rs2 = 7; id_bsel = BSEL_IMM; id_imm = 'h66;
        id_rs2_data = 'h70; id_asel = ASEL_PC; id_pc = 'h3000;
        ex(0, 1, 'h3000, 'h66, 'h70, 1);
        // store data makes rs2 in use
        nx(); id_valid = 1; ex_is_load = 1; ex_rd = 7; id_rs2 = 7; id_bsel = BSEL_IMM; id_store = 1;
        ex(1, 0, 0, 0, 0, 2);
        // EX is a bubble, so no hazard despite matching load
        nx(); id_valid = 1; ex_is_load = 1; ex_rd = 7; id_rs1 = 7; id_rs1_data = 'h22;
        id_asel = ASEL_REG; id_bsel = BSEL_IMM; id_imm = 5;
        ex(0, 1, 'h22, 5, 0, 2);
        // load to x0 is never a hazard
        nx(); id_valid = 1; ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_asel = ASEL_REG;
        id_bsel = BSEL_IMM; id_imm = 'h44;
        ex(0, 1, 0, 'h44, 0, 2);
        nx(); id_valid = 1; id_asel = ASEL_PC; id_pc = 'h4000; id_bsel = BSEL_IMM; id_imm = 'h44;
        id_rs2 = 1; id_rs2_data = 'h11;
        ex(0, 1, 'h4000, 'h44, 'h11, 2);
        // stall holds EX and masks hazard
        for (int i = 0; i < 3; i++) begin
            nx(); stall = 1; id_valid = 1; id_asel = ASEL_REG; id_rs1 = 3;
            id_rs1_data = 64'(i + 1); ex_is_load = 1; ex_rd = 3;
            ex(0, 1, 'h4000, 'h44, 'h11, 2);
        end
        // flush beats stall
        nx(); stall = 1; flush = 1; id_valid = 1; id_asel = ASEL_PC; id_pc = 'h9;
        ex(0, 0, 0, 0, 0, 2);
        nx(); id_valid = 1; id_asel = ASEL_PC; id_pc = 'h5000;
        ex(0, 1, 'h5000, 0, 0, 2);
        // flush beats hazard, no count
        nx(); flush = 1; id_valid = 1; ex_is_load = 1; ex_rd = 4; id_rs1 = 4; id_asel = ASEL_REG;
        ex(1, 0, 0, 0, 0, 2);
        // counter reaches all-ones then saturates
        nx(); id_valid = 1; id_asel = ASEL_PC; id_pc = 'h6000;
        ex(0, 1, 'h6000, 0, 0, 2);
        nx(); id_valid = 1; ex_is_load = 1; ex_rd = 4; id_rs1 = 4; id_asel = ASEL_REG;
        ex(1, 0, 0, 0, 0, 3);
        nx(); id_valid = 1; id_asel = ASEL_PC; id_pc = 'h6100;
        ex(0, 1, 'h6100, 0, 0, 3);
        nx(); id_valid = 1; ex_is_load = 1; ex_rd = 4; id_rs1 = 4; id_asel = ASEL_REG;
        ex(1, 0, 0, 0, 0, 3);
        nx(); id_valid = 1; id_asel = ASEL_PC; id_pc = 'h7000; id_bsel = BSEL_IMM; id_imm = 'h77;
        ex(0, 1, 'h7000, 'h77, 0, 3);
        nx(); stall = 1; id_valid = 1; id_asel = ASEL_PC; id_pc = 'hFFFF;
        ex(0, 1, 'h7000, 'h77, 0, 3);

        w = 0;
        while (q.size() != 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        chk("drain", -2, 64'(q.size()), 64'd0);

        // asynchronous reset while stalled, checked before the next edge
        @(negedge clk);
        #2;
        rstn = 0;
        #1;
        chk("arst ex_valid", -3, {63'd0, ex_valid}, 64'd0);
        chk("arst ex_a", -3, ex_a, 64'd0);
        chk("arst ex_b", -3, ex_b, 64'd0);
        chk("arst ex_sdata", -3, ex_sdata, 64'd0);
        chk("arst hazard_cnt", -3, {62'd0, hazard_cnt}, 64'd0);
        chk("arst hazard_stall", -3, {63'd0, hazard_stall}, 64'd0);

        // first edge after release captures normally
        nx(); rstn = 1; id_valid = 1; id_asel = ASEL_PC; id_pc = 'h8000;
        ex(0, 1, 'h8000, 0, 0, 0);

        w = 0;
        while (q.size() != 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        @(negedge clk);
        chk("final drain", -4, 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
